stat_display: RTL and testbench

STAT_DISPLAY -- requirements
Module: stat_display

---
 rtl/stat_display_pkg.sv | 37 +++
 rtl/stat_display_hex_to_seg.sv | 19 +
 rtl/stat_display.sv | 162 ++++++++++++++++
 tb/tb_stat_display.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stat_display_pkg.sv
// Shared definitions for the counter display: selection encodings and
// active-low seven-segment glyphs ({g,f,e,d,c,b,a}, 0 = segment lit).
package stat_display_pkg;

    // Which performance counter feeds the snapshot; SEL_BAD is never
    // entered in normal operation and recovers to SEL_CYCLE.
    typedef enum logic [1:0] {
        SEL_CYCLE  = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_BAD    = 2'd3
    } sel_t;

    localparam int NIB_W = 4;
    localparam int IDX_W = 3;

    // Hex glyphs 0..F, active-low.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All segments dark.
    localparam logic [6:0] BLANK_GLYPH = 7'h7F;

    // Selection that follows the given one in the 0 -> 1 -> 2 -> 0 cycle.
    function automatic sel_t next_sel(input sel_t s);
        case (s)
            SEL_CYCLE:  return SEL_BRANCH;
            SEL_BRANCH: return SEL_JUMP;
            default:    return SEL_CYCLE;
        endcase
    endfunction

endpackage

// File: rtl/stat_display_hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder with a blank
// override that darkens every segment.
module hex_to_seg
    import stat_display_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] segs
);

    // Glyph lookup, blank wins over the nibble value.
    always_comb begin
        segs = HEX_GLYPH[nibble];
        if (blank) begin
            segs = BLANK_GLYPH;
        end
    end

endmodule

// File: rtl/stat_display.sv
// Multiplexed 8-digit hex display of one of three performance counters.
// A debounced button cycles the selection, freeze holds the shown value,
// and the decimal point of digit 0 marks the frozen state.
// Optional macro STAT_BLANK_LEADING_EN blanks leading zero digits
// (digit 0 always shows); without it all eight digits are displayed.
module stat_display
    import stat_display_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int NDIG     = 8
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [31:0]     count_cycle,
    input  logic [31:0]     count_b,
    input  logic [31:0]     count_j,
    input  logic            sel_next,
    input  logic            freeze,
    output logic [NDIG-1:0] an,
    output logic [7:0]      seg,
    output logic [1:0]      sel,
    output logic            frozen
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    sel_t             sel_q;
    sel_t             sel_d;
    logic             sel_prev;
    logic             primed;
    logic             rise;
    logic             adv;
    logic             reload;
    logic [31:0]      picked;
    logic [31:0]      snapshot;
    logic [DIV_W-1:0] div_cnt;
    logic [IDX_W-1:0] idx;
    logic [3:0]       nibble;
    logic             blank;
    logic [6:0]       glyph;

    // Edge detector; primed stays low for the first clock after reset so a
    // button already held at release is treated as old, not a new press.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_prev <= 1'b0;
            primed   <= 1'b0;
        end else begin
            sel_prev <= sel_next;
            primed   <= 1'b1;
        end
    end

    assign rise = sel_next & ~sel_prev & primed;

    // Selection state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sel_q <= SEL_CYCLE;
        end else begin
            sel_q <= sel_d;
        end
    end

    // Next selection: advance on a press, recover from the illegal code.
    always_comb begin
        sel_d = sel_q;
        adv   = 1'b0;
        case (sel_q)
            SEL_CYCLE, SEL_BRANCH, SEL_JUMP: begin
                if (rise) begin
                    sel_d = next_sel(sel_q);
                    adv   = 1'b1;
                end
            end
            default: begin
                sel_d = SEL_CYCLE;
                adv   = 1'b1;
            end
        endcase
    end

    assign sel = sel_q;

    // Counter currently routed to the snapshot.
    always_comb begin
        picked = count_cycle;
        case (sel_q)
            SEL_BRANCH: picked = count_b;
            SEL_JUMP:   picked = count_j;
            default:    picked = count_cycle;
        endcase
    end

    // Snapshot tracks the selected counter unless frozen; a fresh selection
    // is loaded once even while frozen so the display never shows a value
    // belonging to the previous counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            reload   <= 1'b0;
            snapshot <= 32'd0;
        end else begin
            reload <= adv;
            if (!freeze || reload) begin
                snapshot <= picked;
            end
        end
    end

    // Registered copy of freeze, used for the decimal point.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            frozen <= 1'b0;
        end else begin
            frozen <= freeze;
        end
    end

    // Scan divider and digit index; the index wraps naturally at 8.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            idx     <= idx + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign nibble = snapshot[{idx, 2'b00} +: NIB_W];

    // Blank decision for the digit being driven.
    always_comb begin
        blank = 1'b0;
`ifdef STAT_BLANK_LEADING_EN
        if ((idx != '0) && ((snapshot >> {idx, 2'b00}) == 32'd0)) begin
            blank = 1'b1;
        end
`endif
    end

    hex_to_seg u_hex_to_seg (
        .nibble (nibble),
        .blank  (blank),
        .segs   (glyph)
    );

    // Anode and segment outputs registered together so they stay aligned.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            an  <= ~{{(NDIG-1){1'b0}}, 1'b1};
            seg <= {1'b1, HEX_GLYPH[0]};
        end else begin
            an  <= ~({{(NDIG-1){1'b0}}, 1'b1} << idx);
            seg <= {~(frozen && (idx == '0)), glyph};
        end
    end

endmodule

// File: tb/tb_stat_display.sv
// Directed bench for stat_display with a 4-clock digit dwell.
module tb_stat_display;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] count_cycle;
    logic [31:0] count_b;
    logic [31:0] count_j;
    logic        sel_next;
    logic        freeze;
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [1:0]  sel;
    logic        frozen;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stat_display #(.SCAN_DIV(SCAN_DIV), .NDIG(8)) dut (
        .clk         (clk),
        .clr         (clr),
        .count_cycle (count_cycle),
        .count_b     (count_b),
        .count_j     (count_j),
        .sel_next    (sel_next),
        .freeze      (freeze),
        .an          (an),
        .seg         (seg),
        .sel         (sel),
        .frozen      (frozen)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns on the first sample of a new digit-0 dwell.
    task automatic wait_digit0(output bit ok);
        logic [7:0] prev;
        ok   = 1'b0;
        prev = an;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (an == 8'hFE && prev != 8'hFE) begin
                ok = 1'b1;
                break;
            end
            prev = an;
        end
    endtask

    task automatic test_reset;
        logic [7:0] exp_an;
        logic [7:0] exp_seg;
        clr = 1'b1; count_cycle = 32'h0000_1234; count_b = 32'd0; count_j = 32'd0;
        sel_next = 1'b0; freeze = 1'b0;
        step(3);
        checks++; if (an !== 8'hFE) begin failures++; $display("FAIL reset_an got=%h exp=%h", an, 8'hFE); end
        checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL reset_seg got=%h exp=%h", seg, 8'hC0); end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL reset_frozen got=%b exp=0", frozen); end
        clr = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step(1);
            exp_an  = (n <= 4) ? 8'hFE : 8'hFD;
            exp_seg = (n <= 4) ? 8'h99 : 8'hB0;
            checks++; if (an !== exp_an) begin failures++; $display("FAIL release_an n=%0d got=%h exp=%h", n, an, exp_an); end
            if (n >= 2) begin
                checks++; if (seg !== exp_seg) begin failures++; $display("FAIL release_seg n=%0d got=%h exp=%h", n, seg, exp_seg); end
            end
        end
    endtask

    task automatic test_scan;
        logic [7:0] tab [8] = '{8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        logic [7:0] exp_an;
        bit ok;
        wait_digit0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL scan_timeout got=0 exp=1"); end
        else begin
            for (int k = 0; k < 32; k++) begin
                if (k > 0) step(1);
                exp_an = ~(8'd1 << (k / 4));
                checks++; if (an !== exp_an) begin failures++; $display("FAIL scan_an k=%0d got=%h exp=%h", k, an, exp_an); end
                checks++; if (seg !== tab[k / 4]) begin failures++; $display("FAIL scan_seg k=%0d got=%h exp=%h", k, seg, tab[k / 4]); end
            end
        end
    endtask

    task automatic test_select;
        logic [1:0] exp_sel [3] = '{2'd1, 2'd2, 2'd0};
        logic [7:0] exp_d0  [3] = '{8'h92, 8'hF8, 8'h99};
        bit ok;
        count_cycle = 32'h0000_1234; count_b = 32'h0000_00A5; count_j = 32'h0000_0007;
        for (int i = 0; i < 3; i++) begin
            sel_next = 1'b1;
            step(1);
            checks++; if (sel !== exp_sel[i]) begin failures++; $display("FAIL select_sel i=%0d got=%0d exp=%0d", i, sel, exp_sel[i]); end
            sel_next = 1'b0;
            step(3);
            wait_digit0(ok);
            checks++; if (!ok) begin failures++; $display("FAIL select_timeout i=%0d got=0 exp=1", i); end
            else begin
                checks++; if (seg !== exp_d0[i]) begin failures++; $display("FAIL select_seg i=%0d got=%h exp=%h", i, seg, exp_d0[i]); end
            end
        end
    endtask

    task automatic test_hold;
        sel_next = 1'b1;
        step(1);
        checks++; if (sel !== 2'd1) begin failures++; $display("FAIL hold_first got=%0d exp=1", sel); end
        step(19);
        checks++; if (sel !== 2'd1) begin failures++; $display("FAIL hold_20clk got=%0d exp=1", sel); end
        sel_next = 1'b0;
        step(2);
        checks++; if (sel !== 2'd1) begin failures++; $display("FAIL hold_release got=%0d exp=1", sel); end
        for (int i = 0; i < 2; i++) begin
            sel_next = 1'b1; step(1); sel_next = 1'b0; step(2);
        end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL hold_return got=%0d exp=0", sel); end
    endtask

    task automatic test_freeze;
        logic [7:0] exp_other;
        bit ok;
`ifdef STAT_BLANK_LEADING_EN
        exp_other = 8'hFF;
`else
        exp_other = 8'hC0;
`endif
        count_cycle = 32'h0000_0005; freeze = 1'b0;
        step(3);
        freeze = 1'b1;
        step(2);
        for (int i = 0; i < 40; i++) begin
            count_cycle = count_cycle + 32'd1;
            step(1);
            checks++; if (frozen !== 1'b1) begin failures++; $display("FAIL freeze_flag i=%0d got=%b exp=1", i, frozen); end
            if (an == 8'hFE) begin
                checks++; if (seg !== 8'h12) begin failures++; $display("FAIL freeze_d0 i=%0d got=%h exp=%h", i, seg, 8'h12); end
            end else begin
                checks++; if (seg !== exp_other) begin failures++; $display("FAIL freeze_dn i=%0d an=%h got=%h exp=%h", i, an, seg, exp_other); end
            end
        end
        // Selection change while frozen loads the new counter exactly once.
        count_b = 32'h0000_00A5;
        sel_next = 1'b1; step(1); sel_next = 1'b0;
        step(1);
        count_b = 32'h0000_003C;
        step(3);
        wait_digit0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL freeze_sel_timeout got=0 exp=1"); end
        else begin
            checks++; if (seg !== 8'h12) begin failures++; $display("FAIL freeze_sel_load got=%h exp=%h", seg, 8'h12); end
        end
        freeze = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sel_next = 1'b1; step(1); sel_next = 1'b0; step(2);
        end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL unfreeze_sel got=%0d exp=0", sel); end
        checks++; if (frozen !== 1'b0) begin failures++; $display("FAIL unfreeze_flag got=%b exp=0", frozen); end
        count_cycle = 32'h0000_00A7;
        wait_digit0(ok);
        checks++; if (!ok) begin failures++; $display("FAIL track_timeout got=0 exp=1"); end
        else begin
            checks++; if (seg !== 8'hF8) begin failures++; $display("FAIL track_d0 got=%h exp=%h", seg, 8'hF8); end
            count_cycle = 32'h0000_0008;
            step(2);
            checks++; if (an !== 8'hFE) begin failures++; $display("FAIL track_an got=%h exp=%h", an, 8'hFE); end
            checks++; if (seg !== 8'h80) begin failures++; $display("FAIL track_latency got=%h exp=%h", seg, 8'h80); end
        end
    endtask

    task automatic test_reset_mid_scan;
        logic [7:0] exp_an;
        bit found;
        count_cycle = 32'h0000_1234;
        sel_next = 1'b1; step(1); sel_next = 1'b0; step(1);
        checks++; if (sel !== 2'd1) begin failures++; $display("FAIL midrst_presel got=%0d exp=1", sel); end
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            step(1);
            if (an == 8'hDF) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL midrst_timeout got=0 exp=1"); end
        #2;
        clr = 1'b1; sel_next = 1'b1;
        #1;
        checks++; if (an !== 8'hFE) begin failures++; $display("FAIL midrst_an_async got=%h exp=%h", an, 8'hFE); end
        checks++; if (seg !== 8'hC0) begin failures++; $display("FAIL midrst_seg_async got=%h exp=%h", seg, 8'hC0); end
        checks++; if (sel !== 2'd0) begin failures++; $display("FAIL midrst_sel_async got=%0d exp=0", sel); end
        step(2);
        clr = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step(1);
            exp_an = (n <= 4) ? 8'hFE : 8'hFD;
            checks++; if (an !== exp_an) begin failures++; $display("FAIL midrst_scan n=%0d got=%h exp=%h", n, an, exp_an); end
            checks++; if (sel !== 2'd0) begin failures++; $display("FAIL midrst_held_btn n=%0d got=%0d exp=0", n, sel); end
        end
        sel_next = 1'b0;
        step(2);
    endtask

    task automatic test_leading;
        logic [31:0] vals [2] = '{32'h0000_0000, 32'h0001_0000};
`ifdef STAT_BLANK_LEADING_EN
        logic [7:0] tab [2][8] = '{
            '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
            '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF}};
`else
        logic [7:0] tab [2][8] = '{
            '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0},
            '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0}};
`endif
        logic [7:0] exp_an;
        bit ok;
        for (int v = 0; v < 2; v++) begin
            count_cycle = vals[v];
            step(3);
            wait_digit0(ok);
            checks++; if (!ok) begin failures++; $display("FAIL leading_timeout v=%0d got=0 exp=1", v); end
            else begin
                for (int k = 0; k < 32; k++) begin
                    if (k > 0) step(1);
                    exp_an = ~(8'd1 << (k / 4));
                    checks++; if (an !== exp_an) begin failures++; $display("FAIL leading_an v=%0d k=%0d got=%h exp=%h", v, k, an, exp_an); end
                    checks++; if (seg !== tab[v][k / 4]) begin failures++; $display("FAIL leading_seg v=%0d k=%0d got=%h exp=%h", v, k, seg, tab[v][k / 4]); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_select();
        test_hold();
        test_freeze();
        test_reset_mid_scan();
        test_leading();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
